// File: rtl/vid_tpg_if.sv
// vid_tpg_if: pixel type (video_pkg) and raster sideband interface shared along the pixel pipeline.
package video_pkg;
   localparam int PX_W = 8;
   localparam int X_W  = 12;
   localparam int Y_W  = 12;
   typedef struct packed {
      logic [PX_W-1:0] r;
      logic [PX_W-1:0] g;
      logic [PX_W-1:0] b;
   } pixel_t;
endpackage

interface vid_sideband_if;
   import video_pkg::*;
   logic           de;
   logic           sof;
   logic           eol;
   logic [X_W-1:0] x;
   logic [Y_W-1:0] y;
   modport source (output de, sof, eol, x, y);
   modport sink   (input  de, sof, eol, x, y);
endinterface

// File: rtl/vid_tpg.sv
// vid_tpg: raster timing generator and test-pattern source (bars, ramp, checker, solid white).
// Define VID_TPG_SCROLL_EN to scroll ramp and checker left one pixel per frame.
module vid_tpg
   import video_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [1:0]     pattern_sel,
   output pixel_t         px_out,
   vid_sideband_if.source sb_out,
   output logic           hsync,
   output logic           vsync
);
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BW    = BAR_W > 1 ? $clog2(BAR_W) : 1;

   logic [HW-1:0]   h_q, h_d;
   logic [VW-1:0]   v_q, v_d;
   logic [BW-1:0]   bx_q, bx_d;
   logic [2:0]      bi_q, bi_d;
   logic [1:0]      pat_q, pat_d;
   logic            run_q;
   logic            de_q, de_d, sof_q, sof_d, eol_q, eol_d, hs_q, hs_d, vs_q, vs_d;
   logic [X_W-1:0]  x_q, x_d;
   logic [Y_W-1:0]  y_q, y_d;
   pixel_t          px_q, px_d;
   logic            act, h_wrap, f_wrap, origin;
   logic [PX_W-1:0] xs;

`ifdef VID_TPG_SCROLL_EN
   logic [7:0] fc_q, fc_d;
   assign fc_d = !en ? '0 : f_wrap ? fc_q + 1'b1 : fc_q;
   assign xs   = PX_W'(h_q) + PX_W'(fc_q);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) fc_q <= '0;
      else fc_q <= fc_d;
`else
   assign xs = PX_W'(h_q);
`endif

   always_comb begin
      h_wrap = h_q == HW'(H_TOT - 1);
      f_wrap = en && h_wrap && v_q == VW'(V_TOT - 1);
      h_d    = !en || h_wrap ? '0 : h_q + 1'b1;
      v_d    = !en ? '0 : !h_wrap ? v_q : v_q == VW'(V_TOT - 1) ? '0 : v_q + 1'b1;
      origin = en && h_q == '0 && v_q == '0;
      pat_d  = origin ? pattern_sel : pat_q;
      // Bar index tracks h_cnt through a per-bar sub-counter instead of dividing
      bx_d   = h_d == '0 || bx_q == BW'(BAR_W - 1) ? '0 : bx_q + 1'b1;
      bi_d   = h_d == '0 ? '0 : bx_q == BW'(BAR_W - 1) ? bi_q + 1'b1 : bi_q;
      // Outputs keep reflecting the raster for the one cycle after en drops
      act    = en || run_q;
      de_d   = act && h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
      sof_d  = de_d && h_q == '0 && v_q == '0;
      eol_d  = de_d && h_q == HW'(H_ACTIVE - 1);
      x_d    = de_d ? X_W'(h_q) : '0;
      y_d    = de_d ? Y_W'(v_q) : '0;
      hs_d   = (act && h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC)) ^ ~SYNC_POL;
      vs_d   = (act && v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC)) ^ ~SYNC_POL;
      px_d   = '0;
      if (de_d)
         case (pat_d)
            2'd0:    px_d = {{PX_W{~bi_q[1]}}, {PX_W{~bi_q[2]}}, {PX_W{~bi_q[0]}}};
            2'd1:    px_d = {xs, xs, xs};
            2'd2:    px_d = {3*PX_W{xs[3] ^ v_q[3]}};
            default: px_d = '1;
         endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         h_q   <= '0;
         v_q   <= '0;
         bx_q  <= '0;
         bi_q  <= '0;
         pat_q <= '0;
         run_q <= 1'b0;
         de_q  <= 1'b0;
         sof_q <= 1'b0;
         eol_q <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         px_q  <= '0;
         hs_q  <= ~SYNC_POL;
         vs_q  <= ~SYNC_POL;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         bx_q  <= bx_d;
         bi_q  <= bi_d;
         pat_q <= pat_d;
         run_q <= en;
         de_q  <= de_d;
         sof_q <= sof_d;
         eol_q <= eol_d;
         x_q   <= x_d;
         y_q   <= y_d;
         px_q  <= px_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end

   assign px_out     = px_q;
   assign sb_out.de  = de_q;
   assign sb_out.sof = sof_q;
   assign sb_out.eol = eol_q;
   assign sb_out.x   = x_q;
   assign sb_out.y   = y_q;
   assign hsync      = hs_q;
   assign vsync      = vs_q;
endmodule
